// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock controller.
// Holds the mode state enum, the key bundle and the 24h -> 12h display helper.
package alarm_clock_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME,
        SET_TIME,
        SET_ALARM,
        RINGING,
        SNOOZE
    } state_e;

    localparam int SEC_PER_MIN = 60;
    localparam int HR_PER_DAY  = 24;
    localparam int HR_HALF     = 12;

    typedef struct packed {
        logic mode;
        logic hour;
        logic min;
        logic snooze;
        logic stop;
    } keys_t;

    function automatic logic [3:0] hour12(input logic [4:0] hr24);
        return (hr24 >= 5'(HR_HALF)) ? 4'(hr24 - 5'(HR_HALF)) : hr24[3:0];
    endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// One-second tick generator: a single-cycle pulse once every TICK_DIV clocks.
// While hold is high the divider is parked at zero so counting restarts cleanly.
module alarm_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic hold,
    output logic tick
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // NOTE: state updates use <= so every register samples pre-edge values; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (hold) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Mode/alarm controller in front of TIME_COUNTER: key edges become increment pulses,
// the alarm time is held and compared, and the ring/snooze sequence runs here.
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       KEY_MODE,
    input  logic       KEY_HOUR,
    input  logic       KEY_MIN,
    input  logic       KEY_SNOOZE,
    input  logic       KEY_STOP,
    input  logic       ALARM_EN,
    input  logic [3:0] HOURS_IN,
    input  logic [5:0] MINS_IN,
    input  logic       AM_PM_IN,
    output logic       HOURS,
    output logic       MINS,
    output logic       SECS,
    output logic [3:0] ALARM_HOURS,
    output logic [5:0] ALARM_MINS,
    output logic       ALARM_AM_PM,
    output logic       DISP_ALARM,
    output logic       RING
);

    localparam int SNOOZE_SEC = SNOOZE_MIN * SEC_PER_MIN;
    localparam int RW = (RING_SEC > 0) ? $clog2(RING_SEC + 1) : 1;
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);

    state_e        state, state_next;
    keys_t         key_now, key_prev, key_rise;
    logic          match, match_prev, match_rise;
    logic          tick;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snooze_cnt;
    logic [4:0]    alarm_hr24, hr24_next;
    logic [5:0]    alarm_min, min_next;

    assign key_now    = {KEY_MODE, KEY_HOUR, KEY_MIN, KEY_SNOOZE, KEY_STOP};
    assign key_rise   = key_now & ~key_prev;
    assign match      = ALARM_EN &&
                        ({AM_PM_IN, HOURS_IN, MINS_IN} == {ALARM_AM_PM, ALARM_HOURS, ALARM_MINS});
    assign match_rise = match && !match_prev;

    // Holding on the next state keeps SECS low from the very first SET_TIME cycle.
    alarm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (state_next == SET_TIME),
        .tick    (tick)
    );

    assign SECS       = tick;
    assign RING       = (state == RINGING);
    assign DISP_ALARM = (state == SET_ALARM);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            SHOW_TIME: begin
                if (match_rise)         state_next = RINGING;
                else if (key_rise.mode) state_next = SET_TIME;
            end
            SET_TIME:  if (key_rise.mode) state_next = SET_ALARM;
            SET_ALARM: if (key_rise.mode) state_next = SHOW_TIME;
            RINGING: begin
                if (!ALARM_EN || key_rise.stop)          state_next = SHOW_TIME;
                else if (key_rise.snooze)                state_next = SNOOZE;
                else if (tick && ring_cnt == RING_LAST)  state_next = SHOW_TIME;
            end
            SNOOZE: begin
                if (!ALARM_EN || key_rise.stop)             state_next = SHOW_TIME;
                else if (tick && snooze_cnt == SNOOZE_LAST) state_next = RINGING;
            end
            default: state_next = SHOW_TIME;
        endcase
    end

    always_comb begin
        hr24_next = alarm_hr24;
        min_next  = alarm_min;
        if (state == SET_ALARM) begin
            if (key_rise.hour)
                hr24_next = (alarm_hr24 == 5'(HR_PER_DAY - 1)) ? '0 : alarm_hr24 + 5'd1;
            if (key_rise.min)
                min_next = (alarm_min == 6'(SEC_PER_MIN - 1)) ? '0 : alarm_min + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= SHOW_TIME;
            key_prev    <= '0;
            match_prev  <= 1'b0;
            ring_cnt    <= '0;
            snooze_cnt  <= '0;
            alarm_hr24  <= '0;
            alarm_min   <= '0;
            HOURS       <= 1'b0;
            MINS        <= 1'b0;
            ALARM_HOURS <= '0;
            ALARM_MINS  <= '0;
            ALARM_AM_PM <= 1'b0;
        end else begin
            state       <= state_next;
            key_prev    <= key_now;
            match_prev  <= match;
            HOURS       <= (state == SET_TIME) && key_rise.hour;
            MINS        <= (state == SET_TIME) && key_rise.min;
            alarm_hr24  <= hr24_next;
            alarm_min   <= min_next;
            ALARM_HOURS <= hour12(hr24_next);
            ALARM_MINS  <= min_next;
            ALARM_AM_PM <= (hr24_next >= 5'(HR_HALF));

            // Both counters restart on any state entry, including SNOOZE -> RINGING.
            if (state_next != state) begin
                ring_cnt   <= '0;
                snooze_cnt <= '0;
            end else if (tick) begin
                if (state == RINGING) ring_cnt   <= ring_cnt + 1'b1;
                if (state == SNOOZE)  snooze_cnt <= snooze_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Scoreboard bench for alarm_clock_ctrl: a behavioural model predicts every cycle's outputs,
// a negedge monitor pops and compares; directed phases plus a random phase drive it.
module tb_alarm_clock_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_MIN = 1;

    localparam int K_MODE = 4, K_HOUR = 3, K_MIN = 2, K_SNZ = 1, K_STOP = 0;

    typedef enum {M_SHOW, M_SETT, M_SETA, M_RING, M_SNZ} mode_t;

    typedef struct {
        logic       hours;
        logic       mins;
        logic       secs;
        logic [3:0] ah;
        logic [5:0] am;
        logic       ap;
        logic       disp;
        logic       ring;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] keys = '0;
    logic       alarm_en = 1'b0;
    logic [3:0] hours_in = '0;
    logic [5:0] mins_in = '0;
    logic       am_pm_in = 1'b0;

    logic       HOURS, MINS, SECS, ALARM_AM_PM, DISP_ALARM, RING;
    logic [3:0] ALARM_HOURS;
    logic [5:0] ALARM_MINS;

    int vectors = 0;
    int miscompares = 0;
    int secs_seen = 0, hours_seen = 0, ring_seen = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    // model state
    mode_t m_mode = M_SHOW;
    bit [4:0] m_prev = '0;
    bit    m_mprev = 0;
    int    m_alarm = 0;     // minutes since midnight
    int    m_phase = 0;
    bit    m_secs = 0;
    int    m_ring_s = 0, m_snz_s = 0;

    alarm_clock_ctrl #(
        .TICK_DIV(TICK_DIV), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .KEY_MODE   (keys[K_MODE]),
        .KEY_HOUR   (keys[K_HOUR]),
        .KEY_MIN    (keys[K_MIN]),
        .KEY_SNOOZE (keys[K_SNZ]),
        .KEY_STOP   (keys[K_STOP]),
        .ALARM_EN   (alarm_en),
        .HOURS_IN   (hours_in),
        .MINS_IN    (mins_in),
        .AM_PM_IN   (am_pm_in),
        .HOURS      (HOURS),
        .MINS       (MINS),
        .SECS       (SECS),
        .ALARM_HOURS(ALARM_HOURS),
        .ALARM_MINS (ALARM_MINS),
        .ALARM_AM_PM(ALARM_AM_PM),
        .DISP_ALARM (DISP_ALARM),
        .RING       (RING)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Predicts the outputs visible after the coming clock edge from the current inputs.
    task automatic model_step();
        exp_t  e;
        mode_t nxt;
        bit [4:0] rise;
        bit    match;
        int    a_hr;
        if (!reset_n) begin
            m_mode = M_SHOW; m_prev = '0; m_mprev = 0; m_alarm = 0;
            m_phase = 0; m_secs = 0; m_ring_s = 0; m_snz_s = 0;
            e = '{default: '0};
            exp_q.push_back(e);
            return;
        end
        rise  = keys & ~m_prev;
        a_hr  = m_alarm / 60;
        match = alarm_en && (am_pm_in == (a_hr >= 12)) &&
                (int'(hours_in) == a_hr % 12) && (int'(mins_in) == m_alarm % 60);
        nxt = m_mode;
        case (m_mode)
            M_SHOW: if (match && !m_mprev) nxt = M_RING; else if (rise[K_MODE]) nxt = M_SETT;
            M_SETT: if (rise[K_MODE]) nxt = M_SETA;
            M_SETA: if (rise[K_MODE]) nxt = M_SHOW;
            M_RING: begin
                if (!alarm_en || rise[K_STOP]) nxt = M_SHOW;
                else if (rise[K_SNZ]) nxt = M_SNZ;
                else if (m_secs) begin
                    m_ring_s++;
                    if (m_ring_s == RING_SEC) nxt = M_SHOW;
                end
            end
            M_SNZ: begin
                if (!alarm_en || rise[K_STOP]) nxt = M_SHOW;
                else if (m_secs) begin
                    m_snz_s++;
                    if (m_snz_s == SNOOZE_MIN * 60) nxt = M_RING;
                end
            end
            default: nxt = M_SHOW;
        endcase
        e.hours = (m_mode == M_SETT) && rise[K_HOUR];
        e.mins  = (m_mode == M_SETT) && rise[K_MIN];
        if (m_mode == M_SETA) begin
            if (rise[K_HOUR]) m_alarm = (m_alarm + 60) % 1440;
            if (rise[K_MIN])  m_alarm = (m_alarm / 60) * 60 + (m_alarm % 60 + 1) % 60;
        end
        if (nxt != m_mode) begin
            m_ring_s = 0;
            m_snz_s  = 0;
        end
        if (nxt == M_SETT) begin
            m_phase = 0;
            m_secs  = 0;
        end else begin
            m_phase++;
            m_secs = (m_phase == TICK_DIV);
            if (m_secs) m_phase = 0;
        end
        e.secs = m_secs;
        e.ah   = 4'((m_alarm / 60) % 12);
        e.am   = 6'(m_alarm % 60);
        e.ap   = (m_alarm / 60) >= 12;
        e.disp = (nxt == M_SETA);
        e.ring = (nxt == M_RING);
        m_prev  = keys;
        m_mprev = match;
        m_mode  = nxt;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("HOURS",       {31'd0, HOURS},       {31'd0, mon_e.hours});
            check("MINS",        {31'd0, MINS},        {31'd0, mon_e.mins});
            check("SECS",        {31'd0, SECS},        {31'd0, mon_e.secs});
            check("ALARM_HOURS", {28'd0, ALARM_HOURS}, {28'd0, mon_e.ah});
            check("ALARM_MINS",  {26'd0, ALARM_MINS},  {26'd0, mon_e.am});
            check("ALARM_AM_PM", {31'd0, ALARM_AM_PM}, {31'd0, mon_e.ap});
            check("DISP_ALARM",  {31'd0, DISP_ALARM},  {31'd0, mon_e.disp});
            check("RING",        {31'd0, RING},        {31'd0, mon_e.ring});
        end
        if (SECS === 1'b1)  secs_seen++;
        if (HOURS === 1'b1) hours_seen++;
        if (RING === 1'b1)  ring_seen++;
    end

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input int k, input int n);
        keys[k] = 1'b1;
        repeat (n) cyc();
        keys[k] = 1'b0;
        cyc();
    endtask

    task automatic retrigger();
        mins_in = 6'd2;
        cyc();
        mins_in = 6'd1;
        cyc();
    endtask

    initial begin
        int s0, h0, r0, waited;

        // 1: reset, then free-running seconds
        repeat (3) cyc();
        reset_n = 1'b1;
        s0 = secs_seen;
        repeat (40) cyc();
        settle();
        check("secs_in_40_cycles", 32'(secs_seen - s0), 32'd10);

        // 2: SET_TIME, hour key held high gives one pulse, SECS frozen
        s0 = secs_seen;
        h0 = hours_seen;
        press(K_MODE, 1);
        press(K_HOUR, 5);
        settle();
        check("hours_pulses_held_key", 32'(hours_seen - h0), 32'd1);
        check("secs_in_set_time", 32'(secs_seen - s0), 32'd0);

        // 3: SET_ALARM wraps
        press(K_MODE, 1);
        repeat (13) press(K_HOUR, 1);
        repeat (61) press(K_MIN, 1);
        settle();
        check("alarm_hours_13", {28'd0, ALARM_HOURS}, 32'd1);
        check("alarm_ampm_13", {31'd0, ALARM_AM_PM}, 32'd1);
        check("alarm_mins_61", {26'd0, ALARM_MINS}, 32'd1);
        check("disp_alarm", {31'd0, DISP_ALARM}, 32'd1);
        repeat (11) press(K_HOUR, 1);
        press(K_MODE, 1);
        check("alarm_hours_wrap", {28'd0, ALARM_HOURS}, 32'd0);

        // 4: match rings, times out, no re-ring in same minute
        alarm_en = 1'b1;
        cyc();
        mins_in = 6'd1;
        cyc();
        check("ring_on_match", {31'd0, RING}, 32'd1);
        repeat (30) cyc();
        check("ring_timeout", {31'd0, RING}, 32'd0);
        settle();
        r0 = ring_seen;
        repeat (40) cyc();
        settle();
        check("no_rering_same_minute", 32'(ring_seen - r0), 32'd0);

        // 5: snooze then re-ring; stop+snooze together stops
        retrigger();
        check("ring_again", {31'd0, RING}, 32'd1);
        keys[K_SNZ] = 1'b1;
        cyc();
        check("snooze_ring_off", {31'd0, RING}, 32'd0);
        keys[K_SNZ] = 1'b0;
        waited = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            waited++;
            if (RING === 1'b1) break;
        end
        check("snooze_rering", {31'd0, RING}, 32'd1);
        check("snooze_len_ok", {31'd0, (waited >= 230 && waited <= 250)}, 32'd1);
        keys[K_SNZ]  = 1'b1;
        keys[K_STOP] = 1'b1;
        cyc();
        keys = '0;
        check("stop_snooze_same_cycle", {31'd0, RING}, 32'd0);
        settle();
        r0 = ring_seen;
        repeat (300) cyc();
        settle();
        check("no_ring_after_stop", 32'(ring_seen - r0), 32'd0);

        // 6: reset mid-ring; ALARM_EN drop in SNOOZE
        retrigger();
        check("ring_before_reset", {31'd0, RING}, 32'd1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        check("reset_ring_off", {31'd0, RING}, 32'd0);
        check("reset_alarm_mins", {26'd0, ALARM_MINS}, 32'd0);
        mins_in = 6'd0;
        cyc();
        check("ring_at_0000", {31'd0, RING}, 32'd1);
        press(K_SNZ, 1);
        alarm_en = 1'b0;
        cyc();
        mins_in = 6'd5;
        cyc();
        alarm_en = 1'b1;
        settle();
        r0 = ring_seen;
        repeat (280) cyc();
        settle();
        check("en_off_leaves_snooze", 32'(ring_seen - r0), 32'd0);

        // 7: random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 5; k++)
                if ($urandom_range(0, 5) == 0) keys[k] = ~keys[k];
            if ($urandom_range(0, 19) == 0) begin
                hours_in = 4'($urandom_range(0, 1));
                mins_in  = 6'($urandom_range(0, 2));
                am_pm_in = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 49) == 0) alarm_en = ~alarm_en;
            reset_n = ($urandom_range(0, 399) != 0);
            cyc();
        end
        reset_n = 1'b1;
        settle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
